// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encoding and width limits.
package arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Legal operand width range for the bit-serial units.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/bit_serial_sub_if.sv
// Operand/result handshake bundle for bit_serial_sub.
interface bit_serial_sub_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] DIFF;
    logic             BORROW;
    logic             ZERO;

    // Producer/consumer side that supplies operands and takes results.
    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, DIFF, BORROW, ZERO
    );

    // Subtractor side.
    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, DIFF, BORROW, ZERO
    );
endinterface

// File: rtl/bit_full_sub.sv
// One-bit full subtractor, a - b - bin, built from two half-subtractors and an OR.
module bit_full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    // First half-subtractor: a - b.
    assign hs1_d = a ^ b;
    assign hs1_b = ~a & b;

    // Second half-subtractor: (a - b) - bin.
    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;

    // A borrow out of either stage propagates.
    assign bout  = hs1_b | hs2_b;
endmodule

// File: rtl/bit_serial_sub.sv
// Bit-serial unsigned subtractor: DIFF = (A - B) mod 2^WIDTH, one bit per clock, LSB first.
// WIDTH must lie in 2..32.
module bit_serial_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    bit_serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d_bit;
    logic             br_nxt;
    logic             last;
    logic [WIDTH-1:0] diff_fin;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;

    bit_full_sub u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_nxt)
    );

    // Final bit position is decoded directly so the counter never has to wrap.
    assign last     = (cnt == CW'(WIDTH - 1));
    // Result as it will look once the current bit is shifted in from the top.
    assign diff_fin = {d_bit, d_sr[WIDTH-1:1]};

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.DIFF      = diff_q;
    assign bus.BORROW    = borrow_q;
    assign bus.ZERO      = zero_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode: accept in IDLE, run WIDTH steps, hold result until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.in_valid)  state_nxt = S_SHIFT;
            S_SHIFT: if (last)          state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, serial subtract steps and result latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            d_sr     <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_sr <= bus.A;
                        b_sr <= bus.B;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    d_sr <= diff_fin;
                    br   <= br_nxt;
                    if (!last) cnt <= cnt + 1'b1;
                    if (last) begin
                        diff_q   <= diff_fin;
                        borrow_q <= br_nxt;
                        zero_q   <= ~|diff_fin;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
